// File: rtl/prio_cmd_seq.sv
// Command sequencer feeding the priority FSM stage: queues {len, sel} commands and replays each as a `do` burst plus a `sel` window.
// Optional completed-command counter enabled by defining PRIO_CMD_SEQ_STATS_EN.
module prio_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int LEN_W = 4,
   parameter int TMO   = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_sel,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             do_req,
   output logic [1:0]       sel,
   input  logic             f,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic             err_clr,
   output logic [15:0]      done_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TMO);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BURST  = 2'd1,
      S_DROP   = 2'd2,
      S_WAIT_F = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [LEN_W+1:0]   mem [DEPTH];
   logic [AW:0]        wr_ptr, rd_ptr;
   logic               full, empty, push, pop;
   logic [LEN_W+1:0]   head;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [TW-1:0]      tmr_q, tmr_d;
   logic               do_req_d, done_d, err_set;
   logic [1:0]         sel_d;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign head      = mem[rd_ptr[AW-1:0]];
   assign busy      = (state_q != S_IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {cmd_sel, cmd_len};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      do_req_d = do_req;
      sel_d    = sel;
      len_d    = len_q;
      tmr_d    = tmr_q;
      done_d   = 1'b0;
      err_set  = 1'b0;
      pop      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               len_d    = (head[LEN_W-1:0] == '0) ? LEN_W'(1) : head[LEN_W-1:0];
               do_req_d = 1'b1;
               sel_d    = head[LEN_W+1:LEN_W];
               state_d  = S_BURST;
            end
         end
         S_BURST: begin
            len_d = len_q - 1'b1;
            if (len_q == LEN_W'(1)) begin
               do_req_d = 1'b0;
               state_d  = S_DROP;
            end
         end
         S_DROP: begin
            // Only sel==3 leads the downstream stage to LAST, so only then is `f` awaited.
            if (sel == 2'd3) begin
               tmr_d   = '0;
               state_d = S_WAIT_F;
            end else begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WAIT_F: begin
            tmr_d = tmr_q + 1'b1;
            if (f) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (tmr_q == TW'(TMO - 1)) begin
               err_set = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         do_req  <= 1'b0;
         sel     <= 2'd0;
         len_q   <= '0;
         tmr_q   <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         do_req  <= do_req_d;
         sel     <= sel_d;
         len_q   <= len_d;
         tmr_q   <= tmr_d;
         done    <= done_d;
         if (err_set)      err <= 1'b1;
         else if (err_clr) err <= 1'b0;
      end
   end

`ifdef PRIO_CMD_SEQ_STATS_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              cnt_q <= '0;
      else if (err_clr)                        cnt_q <= '0;
      else if (done_d && (cnt_q != 16'hFFFF))  cnt_q <= cnt_q + 1'b1;
   end

   assign done_cnt = cnt_q;
`else
   assign done_cnt = 16'd0;
`endif

endmodule

// File: doc/prio_cmd_seq.md
Name: prio_cmd_seq

Overview:
- Command sequencer directly upstream of the priority FSM stage; it drives that stage's `do` and `sel` inputs and consumes its `f` pulse.
- Host pushes commands into a small internal FIFO. Each command is a burst length plus a select code.
- The block replays each command as a `do` burst followed by a `sel` decision window, then waits for `f` when the command requests the LAST path.
- Reports completion, and a timeout if `f` never arrives.

Parameters:
- DEPTH, 4: command FIFO entries; power of 2, at least 2.
- LEN_W, 4: width of the burst-length field.
- TMO, 6: cycles to wait for `f` in WAIT_F before flagging a timeout; at least 3.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_sel  in  2  select code to present after the burst
- cmd_len  in  LEN_W  `do` burst length in cycles; 0 is treated as 1
- do_req  out  1  registered; connects to downstream `do`
- sel  out  2  registered; connects to downstream `sel`
- f  in  1  downstream LAST pulse
- busy  out  1  FSM not in IDLE, or FIFO non-empty
- done  out  1  one-cycle pulse per completed command
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err; set has priority if both occur in the same cycle
- done_cnt  out  16  completed-command counter (see Optional Feature)

Behaviour:
- Reset values: do_req=0, sel=0, done=0, err=0, done_cnt=0, FIFO empty, state IDLE. Assertion mid-operation aborts immediately and discards queued commands.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full, evaluated before any same-cycle pop. A push into a full FIFO is refused even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
  - A command pushed into an empty FIFO is popped no earlier than the following cycle.
- States:
  - IDLE: if FIFO non-empty, pop. Load len_cnt = max(cmd_len, 1). Set do_req<=1 and sel<=cmd_sel. Go to BURST.
  - BURST: do_req held at 1 for exactly len_cnt cycles.
    - Decrement len_cnt each cycle.
    - On the last cycle: do_req<=0, go to DROP.
  - DROP: one cycle with do_req=0 and sel held.
    - If sel==3: go to WAIT_F, clear the timer.
    - Otherwise: done<=1, go to IDLE.
      - sel==2 returns the downstream stage to IDLE.
      - sel 0/1 parks it in MIDDLE.
  - WAIT_F: timer increments each cycle.
    - If f==1: done<=1, go to IDLE.
    - Else if timer==TMO-1: err<=1, go to IDLE, no done.
- Timing: `f` is expected on the second edge after do_req falls. TMO ≥ 3 guarantees margin.
- sel changes only on the IDLE→BURST transition, together with do_req rising. Because `do` has priority in the downstream MIDDLE state, a new sel never causes a spurious IDLE or LAST decision.
- sel is not reset when returning to IDLE; it holds its last value.
- Back-to-back commands: the minimum gap between do_req bursts is 2 cycles (DROP, then IDLE) on the sel 0/1/2 path. On the sel=3 path it is WAIT_F length + 1.
- An `f` arriving outside WAIT_F is ignored.
- busy deasserts only in IDLE with the FIFO empty.

Optional Feature:
- Macro PRIO_CMD_SEQ_STATS_EN.
- Defined: done_cnt increments on each done pulse and saturates at 16'hFFFF. err_clr also clears done_cnt.
- Undefined: done_cnt is tied to 0, and no counter logic is generated.

Test Plan:
- Reset, then push {len=3, sel=3} → do_req high exactly 3 cycles, then DROP. With the downstream model, f arrives 2 edges after do_req falls; done pulses 1 cycle later; err stays 0.
- Push {len=0, sel=2} → do_req high 1 cycle; done pulses in DROP; no WAIT_F entered; busy falls the cycle after done.
- Push 4 commands with the FIFO at DEPTH=4 and no pops possible (FSM busy) → cmd_ready=0 after the 4th. A 5th push is refused even on a same-cycle pop; all 4 execute in order.
- sel=3 command with f held low → err sets after TMO=6 cycles in WAIT_F; no done. err_clr asserted alongside a new timeout → err stays 1.
- Sequence {2,sel=1}, {2,sel=3} → the downstream stage parks in MIDDLE, then reaches RUN via the second burst, then LAST. Exactly 2 done pulses; done_cnt=2 with PRIO_CMD_SEQ_STATS_EN, otherwise 0.
- Assert rst_n during BURST with 2 commands queued → do_req=0 asynchronously, FIFO empty, busy=0 after release, no further activity.
